spi_cmd_arbiter: RTL and testbench

//  Shares the single SPI master between two command requesters (req0, req1).

---
 rtl/spi_bridge_pkg.sv | 17 +
 rtl/spi_cmd_arbiter_if.sv | 49 ++++
 rtl/spi_cmd_arbiter_tag_fifo.sv | 50 +++++
 rtl/spi_cmd_arbiter.sv | 140 ++++++++++++++
 tb/tb_spi_cmd_arbiter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_bridge_pkg.sv
// Shared constants and types for the SPI command arbiter.
// The command word layout and the response FSM states live here.
package spi_bridge_pkg;

  localparam int CMD_W    = 41;
  localparam int DATA_W   = 32;
  localparam int WR_BIT   = 40;
  localparam int CS_BIT   = 39;
  localparam int ADDR_MSB = 38;
  localparam int ADDR_LSB = 32;

  typedef enum logic {
    R_IDLE,
    R_HOLD
  } rsp_state_e;

endpackage

// File: rtl/spi_cmd_arbiter_if.sv
// Requester, response and TX/RX FIFO signals of the SPI command arbiter.
// The arbiter connects through the slave modport; the bench or fabric drives the master side.
interface spi_cmd_arbiter_if;
  import spi_bridge_pkg::*;

  logic              req0_valid;
  logic [CMD_W-1:0]  req0_cmd;
  logic              req0_ready;
  logic              req1_valid;
  logic [CMD_W-1:0]  req1_cmd;
  logic              req1_ready;

  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_data;
  logic              rsp0_ready;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_data;
  logic              rsp1_ready;

  logic [CMD_W-1:0]  Tx_FIFO_data_out;
  logic              Tx_FIFO_write_en;
  logic              Tx_FIFO_full;
  logic [DATA_W-1:0] Rx_FIFO_data_in;
  logic              Rx_FIFO_read_en;
  logic              Rx_FIFO_empty;

  modport master (
    output req0_valid, req0_cmd, req1_valid, req1_cmd,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    output rsp0_ready, rsp1_ready,
    input  Tx_FIFO_data_out, Tx_FIFO_write_en,
    output Tx_FIFO_full,
    output Rx_FIFO_data_in, Rx_FIFO_empty,
    input  Rx_FIFO_read_en
  );

  modport slave (
    input  req0_valid, req0_cmd, req1_valid, req1_cmd,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    input  rsp0_ready, rsp1_ready,
    output Tx_FIFO_data_out, Tx_FIFO_write_en,
    input  Tx_FIFO_full,
    input  Rx_FIFO_data_in, Rx_FIFO_empty,
    output Rx_FIFO_read_en
  );

endinterface

// File: rtl/spi_cmd_arbiter_tag_fifo.sv
// Tag FIFO: one bit per outstanding read, recording which requester issued it.
// Depth is a power of two so the pointers wrap naturally.
module spi_tag_fifo #(
  parameter int TAG_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       din,
  input  logic                       pop,
  output logic                       dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(TAG_DEPTH):0] count
);

  localparam int AW = $clog2(TAG_DEPTH);

  logic [TAG_DEPTH-1:0] mem;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(TAG_DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/spi_cmd_arbiter.sv
// Round-robin arbiter sharing the SPI master between two requesters, with
// in-order routing of read data back to the requester that issued each read.
module spi_cmd_arbiter
  import spi_bridge_pkg::*;
#(
  parameter int TAG_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  spi_cmd_arbiter_if.slave           bus,
  output logic [$clog2(TAG_DEPTH):0] rd_outstanding,
  output logic                       orphan_err
);

  logic             rr_last;
  logic             tx_we_q;
  logic [CMD_W-1:0] tx_data_q;

  logic             tag_full;
  logic             tag_empty;
  logic             tag_head;
  logic             tag_pop;
  logic             tag_push;

  logic             elig0;
  logic             elig1;
  logic             can_grant;
  logic             grant0;
  logic             grant1;

  rsp_state_e        state;
  rsp_state_e        state_nxt;
  logic              rsp_sel;
  logic [DATA_W-1:0] rsp_data_q;
  logic              capture;
  logic              rx_pop;
  logic              orphan_set;

  // A read may only be accepted while there is room to remember its requester.
  assign elig0 = bus.req0_valid && !(!bus.req0_cmd[WR_BIT] && tag_full);
  assign elig1 = bus.req1_valid && !(!bus.req1_cmd[WR_BIT] && tag_full);

  // Blocking grants in the push cycle limits TX pushes to one every other clock.
  assign can_grant = !bus.Tx_FIFO_full && !tx_we_q;
  assign grant0    = can_grant && elig0 && (!elig1 || rr_last);
  assign grant1    = can_grant && elig1 && (!elig0 || !rr_last);

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  assign tag_push = (grant0 && !bus.req0_cmd[WR_BIT]) ||
                    (grant1 && !bus.req1_cmd[WR_BIT]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last   <= 1'b1;
      tx_we_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      tx_we_q <= grant0 || grant1;
      if (grant0) begin
        rr_last   <= 1'b0;
        tx_data_q <= bus.req0_cmd;
      end else if (grant1) begin
        rr_last   <= 1'b1;
        tx_data_q <= bus.req1_cmd;
      end
    end
  end

  assign bus.Tx_FIFO_write_en = tx_we_q;
  assign bus.Tx_FIFO_data_out = tx_data_q;

  spi_tag_fifo #(
    .TAG_DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tag_push),
    .din   (grant1),
    .pop   (tag_pop),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (rd_outstanding)
  );

  always_comb begin
    state_nxt  = state;
    rx_pop     = 1'b0;
    tag_pop    = 1'b0;
    capture    = 1'b0;
    orphan_set = 1'b0;
    case (state)
      R_IDLE: begin
        if (!bus.Rx_FIFO_empty) begin
          rx_pop = 1'b1;
          if (!tag_empty) begin
            tag_pop   = 1'b1;
            capture   = 1'b1;
            state_nxt = R_HOLD;
          end else begin
            orphan_set = 1'b1;
          end
        end
      end
      R_HOLD: begin
        if (rsp_sel ? bus.rsp1_ready : bus.rsp0_ready) begin
          state_nxt = R_IDLE;
        end
      end
      default: state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= R_IDLE;
      rsp_sel    <= 1'b0;
      rsp_data_q <= '0;
      orphan_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        rsp_sel    <= tag_head;
        rsp_data_q <= bus.Rx_FIFO_data_in;
      end
      if (orphan_set) begin
        orphan_err <= 1'b1;
      end
    end
  end

  assign bus.Rx_FIFO_read_en = rx_pop;
  assign bus.rsp0_valid      = (state == R_HOLD) && !rsp_sel;
  assign bus.rsp1_valid      = (state == R_HOLD) && rsp_sel;
  assign bus.rsp0_data       = rsp_data_q;
  assign bus.rsp1_data       = rsp_data_q;

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Directed bench for spi_cmd_arbiter: arbitration, TX pacing, tag-full
// back-pressure, in-order read routing and orphan RX data.
module tb_spi_cmd_arbiter;
  import spi_bridge_pkg::*;

  logic       clk;
  logic       reset;
  logic [2:0] rd_outstanding;
  logic       orphan_err;

  int n_chk;
  int n_pass;

  localparam logic [CMD_W-1:0] WR_AB = 41'h1_8000_0000_AB;
  localparam logic [CMD_W-1:0] WR_A  = 41'h1_0000_0000_11;
  localparam logic [CMD_W-1:0] WR_B  = 41'h1_0000_0000_22;
  localparam logic [CMD_W-1:0] RD_1  = 41'h0_8100_0000_00;
  localparam logic [CMD_W-1:0] RD_0  = 41'h0_0200_0000_00;

  spi_cmd_arbiter_if bus();

  spi_cmd_arbiter #(
    .TAG_DEPTH (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .rd_outstanding (rd_outstanding),
    .orphan_err     (orphan_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0_valid      = 1'b0;
    bus.req0_cmd        = '0;
    bus.req1_valid      = 1'b0;
    bus.req1_cmd        = '0;
    bus.rsp0_ready      = 1'b0;
    bus.rsp1_ready      = 1'b0;
    bus.Tx_FIFO_full    = 1'b0;
    bus.Rx_FIFO_data_in = '0;
    bus.Rx_FIFO_empty   = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;

    // reset values
    do_reset();
    reset = 1'b1;
    #1;
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_ready1", bus.req1_ready, 0);
    chk("rst_rsp0_valid", bus.rsp0_valid, 0);
    chk("rst_rsp1_valid", bus.rsp1_valid, 0);
    chk("rst_tx_we", bus.Tx_FIFO_write_en, 0);
    chk("rst_tx_data", bus.Tx_FIFO_data_out, 0);
    chk("rst_rx_re", bus.Rx_FIFO_read_en, 0);
    chk("rst_rd_out", rd_outstanding, 0);
    chk("rst_orphan", orphan_err, 0);
    step();
    reset = 1'b0;

    // single write from req0
    bus.req0_valid = 1'b1;
    bus.req0_cmd   = WR_AB;
    #1;
    chk("wr_ready0", bus.req0_ready, 1);
    chk("wr_ready1", bus.req1_ready, 0);
    chk("wr_we_early", bus.Tx_FIFO_write_en, 0);
    step();
    bus.req0_valid = 1'b0;
    #1;
    chk("wr_we", bus.Tx_FIFO_write_en, 1);
    chk("wr_data", bus.Tx_FIFO_data_out, WR_AB);
    chk("wr_rd_out", rd_outstanding, 0);
    step();
    chk("wr_we_pulse", bus.Tx_FIFO_write_en, 0);

    // both requesters continuously valid: alternate grants, push every 2 clk
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_cmd   = WR_A;
    bus.req1_valid = 1'b1;
    bus.req1_cmd   = WR_B;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_ready0", bus.req0_ready, (k % 2 == 0) && ((k / 2) % 2 == 0));
      chk("rr_ready1", bus.req1_ready, (k % 2 == 0) && ((k / 2) % 2 == 1));
      chk("rr_we", bus.Tx_FIFO_write_en, k % 2 == 1);
      if (k % 2 == 1)
        chk("rr_data", bus.Tx_FIFO_data_out, (((k - 1) / 2) % 2 == 0) ? WR_A : WR_B);
      step();
    end

    // TX FIFO full blocks everything; req0 has priority once it clears
    do_reset();
    bus.Tx_FIFO_full = 1'b1;
    bus.req0_valid   = 1'b1;
    bus.req0_cmd     = WR_A;
    bus.req1_valid   = 1'b1;
    bus.req1_cmd     = WR_B;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("full_ready0", bus.req0_ready, 0);
      chk("full_ready1", bus.req1_ready, 0);
      chk("full_we", bus.Tx_FIFO_write_en, 0);
      step();
    end
    bus.Tx_FIFO_full = 1'b0;
    #1;
    chk("unfull_ready0", bus.req0_ready, 1);
    chk("unfull_ready1", bus.req1_ready, 0);
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("unfull_we", bus.Tx_FIFO_write_en, 1);
    chk("unfull_data", bus.Tx_FIFO_data_out, WR_A);

    // req1 read then req0 read; responses routed in order
    do_reset();
    bus.req1_valid = 1'b1;
    bus.req1_cmd   = RD_1;
    #1;
    chk("rd1_ready1", bus.req1_ready, 1);
    step();
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_cmd   = RD_0;
    #1;
    chk("rd0_blocked", bus.req0_ready, 0);
    chk("rd_out_1", rd_outstanding, 1);
    step();
    #1;
    chk("rd0_ready0", bus.req0_ready, 1);
    step();
    bus.req0_valid = 1'b0;
    #1;
    chk("rd_out_2", rd_outstanding, 2);
    chk("rd0_we", bus.Tx_FIFO_write_en, 1);
    chk("rd0_data", bus.Tx_FIFO_data_out, RD_0);
    bus.Rx_FIFO_empty   = 1'b0;
    bus.Rx_FIFO_data_in = 32'hDEAD_BEEF;
    #1;
    chk("rx_pop1", bus.Rx_FIFO_read_en, 1);
    step();
    bus.Rx_FIFO_data_in = 32'h1234_5678;
    #1;
    chk("rsp1_valid", bus.rsp1_valid, 1);
    chk("rsp1_data", bus.rsp1_data, 32'hDEAD_BEEF);
    chk("rsp1_not0", bus.rsp0_valid, 0);
    chk("rd_out_pop", rd_outstanding, 1);
    chk("hold_no_pop", bus.Rx_FIFO_read_en, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      #1;
      chk("hold_valid", bus.rsp1_valid, 1);
      chk("hold_data", bus.rsp1_data, 32'hDEAD_BEEF);
      chk("hold_no_pop", bus.Rx_FIFO_read_en, 0);
    end
    bus.rsp1_ready = 1'b1;
    #1;
    chk("hs_valid", bus.rsp1_valid, 1);
    step();
    bus.rsp1_ready = 1'b0;
    #1;
    chk("post_hs_valid", bus.rsp1_valid, 0);
    chk("rx_pop2", bus.Rx_FIFO_read_en, 1);
    step();
    bus.Rx_FIFO_empty = 1'b1;
    #1;
    chk("rsp0_valid", bus.rsp0_valid, 1);
    chk("rsp0_data", bus.rsp0_data, 32'h1234_5678);
    chk("rsp0_not1", bus.rsp1_valid, 0);
    chk("rd_out_0", rd_outstanding, 0);
    bus.rsp0_ready = 1'b1;
    step();
    bus.rsp0_ready = 1'b0;
    #1;
    chk("rsp0_done", bus.rsp0_valid, 0);

    // tag FIFO full: 5th read held off, writes still pass
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_cmd   = RD_0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("fill_ready0", bus.req0_ready, k % 2 == 0);
      step();
    end
    bus.req1_valid = 1'b1;
    bus.req1_cmd   = WR_B;
    #1;
    chk("tagfull_rd_out", rd_outstanding, 4);
    chk("tagfull_ready0", bus.req0_ready, 0);
    chk("tagfull_wr_ready1", bus.req1_ready, 1);
    step();
    bus.req1_valid = 1'b0;
    step();
    bus.Rx_FIFO_empty   = 1'b0;
    bus.Rx_FIFO_data_in = 32'hCAFE_F00D;
    #1;
    chk("tagfull_ready0_b", bus.req0_ready, 0);
    chk("tagfull_rx_pop", bus.Rx_FIFO_read_en, 1);
    step();
    bus.Rx_FIFO_empty = 1'b1;
    bus.rsp0_ready    = 1'b1;
    #1;
    chk("fifth_ready0", bus.req0_ready, 1);
    chk("fifth_rd_out", rd_outstanding, 3);
    chk("fifth_rsp0", bus.rsp0_data, 32'hCAFE_F00D);
    step();
    bus.req0_valid = 1'b0;
    bus.rsp0_ready = 1'b0;
    #1;
    chk("fifth_rd_out_after", rd_outstanding, 4);
    chk("fifth_rsp0_done", bus.rsp0_valid, 0);

    // RX data with no outstanding read
    do_reset();
    bus.Rx_FIFO_empty   = 1'b0;
    bus.Rx_FIFO_data_in = 32'h0000_0055;
    #1;
    chk("orph_pop", bus.Rx_FIFO_read_en, 1);
    chk("orph_pre", orphan_err, 0);
    step();
    bus.Rx_FIFO_empty = 1'b1;
    #1;
    chk("orph_set", orphan_err, 1);
    chk("orph_rsp0", bus.rsp0_valid, 0);
    chk("orph_rsp1", bus.rsp1_valid, 0);
    chk("orph_one_pop", bus.Rx_FIFO_read_en, 0);
    step();
    step();
    chk("orph_sticky", orphan_err, 1);
    reset = 1'b1;
    #1;
    chk("orph_clear", orphan_err, 0);
    step();
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
